// File: rtl/actor_token_if.sv
// Token channel bundle between two dataflow actors and the token FIFO.
// master: the actor side (drives W_SEND/W_DATA/W_COUNT and R_ACK).
// slave : the FIFO side (drives W_ACK/W_RDY and R_SEND/R_DATA/R_COUNT).
interface actor_token_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  W_SEND;
   logic [DATA_WIDTH-1:0] W_DATA;
   logic [15:0]           W_COUNT;
   logic                  W_ACK;
   logic                  W_RDY;
   logic                  R_SEND;
   logic [DATA_WIDTH-1:0] R_DATA;
   logic [15:0]           R_COUNT;
   logic                  R_ACK;

   modport master (
      output W_SEND, W_DATA, W_COUNT, R_ACK,
      input  W_ACK, W_RDY, R_SEND, R_DATA, R_COUNT
   );

   modport slave (
      input  W_SEND, W_DATA, W_COUNT, R_ACK,
      output W_ACK, W_RDY, R_SEND, R_DATA, R_COUNT
   );
endinterface

// File: rtl/actor_token_fifo.sv
// actor_token_fifo: single-clock first-word-fall-through token channel that
// decouples an upstream actor's firings from a downstream actor, up to DEPTH
// tokens. Full/empty are decided by the occupancy counter alone, so the
// pointers simply wrap modulo DEPTH.
// W_RDY is held low until the first clock edge after reset release (live flop).
// Optional: define ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN to add a sticky ERR
// output flagging protocol violations; it never changes FIFO behaviour.
module actor_token_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic         CLK,
   input  logic         RESET,
   actor_token_if.slave bus
`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
   ,
   output logic         ERR
`endif
);

   localparam int unsigned           DEPTH_U  = DEPTH;
   localparam logic [ADDR_WIDTH:0]   FULL_LVL = DEPTH_U[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   OCC_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   OCC_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   occ_q, occ_d;
   logic                  live_q;

   logic full_s;
   logic empty_s;
   logic w_rdy_s;
   logic push_s;
   logic pop_s;

   // Status flags and the accepted push/pop strobes for this cycle.
   always_comb begin
      full_s  = (occ_q == FULL_LVL);
      empty_s = (occ_q == OCC_ZERO);
      w_rdy_s = live_q & ~full_s;
      push_s  = bus.W_SEND & w_rdy_s;
      pop_s   = bus.R_ACK & ~empty_s;
   end

   // Next-state for pointers and occupancy; simultaneous push/pop keeps the level.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase
   end

   // Control state: pointers, occupancy and the post-reset live flop.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         occ_q    <= OCC_ZERO;
         live_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         live_q   <= 1'b1;
      end
   end

   // Token storage; cleared on reset so R_DATA reads zero until the first push.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= bus.W_DATA;
      end
   end

   assign bus.W_ACK   = push_s;
   assign bus.W_RDY   = w_rdy_s;
   assign bus.R_SEND  = ~empty_s;
   assign bus.R_DATA  = mem_q[rd_ptr_q];
   assign bus.R_COUNT = {{(15-ADDR_WIDTH){1'b0}}, occ_q};

`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
   logic err_q;
   logic viol_s;

   // Any write to a non-ready channel, read of an empty one, or non-unit count.
   always_comb begin
      viol_s = (bus.W_SEND & ~w_rdy_s & live_q)
             | (bus.R_ACK & empty_s)
             | (bus.W_SEND & (bus.W_COUNT != 16'h0001));
   end

   // Sticky protocol error flag, cleared only by reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         err_q <= 1'b0;
      end else if (viol_s) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign ERR = err_q;
`else
   // W_COUNT carries no control meaning without the checker.
   logic unused_count_s;
   assign unused_count_s = ^bus.W_COUNT;
`endif

endmodule

// File: tb/tb_actor_token_fifo.sv
// Self-checking bench for actor_token_fifo: directed scenarios plus randomized
// traffic, all compared against a queue-based model of the token channel.
module tb_actor_token_fifo;

   logic CLK = 1'b0;
   logic RESET = 1'b0;

   actor_token_if #(.DATA_WIDTH(16)) bus ();

`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
   logic ERR;
   actor_token_fifo #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3)) dut (
      .CLK(CLK), .RESET(RESET), .bus(bus), .ERR(ERR));
`else
   actor_token_fifo #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3)) dut (
      .CLK(CLK), .RESET(RESET), .bus(bus));
`endif

   always #5 CLK = ~CLK;

   // Reference model: the channel contents as a plain queue, plus live/err bits.
   logic [15:0] q[$];
   bit          live_m = 1'b0;
   bit          err_m  = 1'b0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   // Advance one clock edge, updating the model from the pre-edge inputs.
   task automatic tick();
      bit          rdy, push, pop, viol;
      logic [15:0] d;
      rdy  = live_m && (q.size() < 8);
      push = bus.W_SEND && rdy;
      pop  = bus.R_ACK && (q.size() > 0);
      viol = (bus.W_SEND && !rdy && live_m) || (bus.R_ACK && q.size() == 0) ||
             (bus.W_SEND && bus.W_COUNT != 16'h0001);
      d = bus.W_DATA;
      @(posedge CLK);
      if (RESET) begin
         if (pop) q.delete(0);
         if (push) q.push_back(d);
         if (viol) err_m = 1'b1;
         live_m = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.W_SEND = 1'b0; bus.W_DATA = 16'h0000; bus.W_COUNT = 16'h0001; bus.R_ACK = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         total_cnt++;
         if (bus.W_RDY !== 1'b0) $display("FAIL reset_rdy[%0d]: got %b want 0", i, bus.W_RDY);
         else pass_cnt++;
      end
      RESET = 1'b1;
      #1;
      total_cnt++;
      if ({bus.W_RDY, bus.W_ACK, bus.R_SEND, bus.R_COUNT, bus.R_DATA} !== {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000})
         $display("FAIL reset_outs: got rdy=%b ack=%b send=%b cnt=%h data=%h want all 0",
                  bus.W_RDY, bus.W_ACK, bus.R_SEND, bus.R_COUNT, bus.R_DATA);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.W_RDY !== 1'b1) $display("FAIL reset_live: W_RDY got %b want 1", bus.W_RDY);
      else pass_cnt++;
`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
      total_cnt++;
      if (ERR !== 1'b0) $display("FAIL reset_err: got %b want 0", ERR);
      else pass_cnt++;
`endif
   endtask

   task automatic test_fill_drain();
      logic [15:0] tok;
      for (int i = 0; i < 8; i++) begin
         bus.W_SEND = 1'b1; bus.W_DATA = 16'h0011 * 16'(i + 1); #1;
         total_cnt++;
         if (bus.W_ACK !== 1'b1) $display("FAIL fill_ack[%0d]: got %b want 1", i, bus.W_ACK);
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if ({bus.R_COUNT, bus.W_RDY} !== {16'h0008, 1'b0})
         $display("FAIL fill_full: got cnt=%h rdy=%b want cnt=0008 rdy=0", bus.R_COUNT, bus.W_RDY);
      else pass_cnt++;
      bus.W_DATA = 16'hDEAD; #1;
      total_cnt++;
      if (bus.W_ACK !== 1'b0) $display("FAIL fill_ninth_ack: got %b want 0", bus.W_ACK);
      else pass_cnt++;
      tick();
      bus.W_SEND = 1'b0; bus.R_ACK = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         tok = 16'h0011 * 16'(i + 1);
         total_cnt++;
         if (bus.R_DATA !== tok) $display("FAIL drain_data[%0d]: got %h want %h", i, bus.R_DATA, tok);
         else pass_cnt++;
         tick();
      end
      bus.R_ACK = 1'b0; #1;
      total_cnt++;
      if ({bus.R_SEND, bus.R_COUNT} !== {1'b0, 16'h0000})
         $display("FAIL drain_empty: got send=%b cnt=%h want 0/0000", bus.R_SEND, bus.R_COUNT);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int peak = 0;
      bus.W_SEND = 1'b1;
      for (int i = 0; i < 5; i++) begin bus.W_DATA = 16'($urandom); tick(); end
      bus.W_SEND = 1'b0; bus.R_ACK = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      bus.R_ACK = 1'b0; bus.W_SEND = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.W_DATA = 16'hA000 + 16'(i); tick();
         if (int'(bus.R_COUNT) > peak) peak = int'(bus.R_COUNT);
      end
      total_cnt++;
      if (peak != 6) $display("FAIL wrap_peak: got %0d want 6", peak);
      else pass_cnt++;
      bus.W_SEND = 1'b0; bus.R_ACK = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         total_cnt++;
         if (bus.R_DATA !== 16'hA000 + 16'(i))
            $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.R_DATA, 16'hA000 + 16'(i));
         else pass_cnt++;
         tick();
      end
      bus.R_ACK = 1'b0;
   endtask

   task automatic test_simultaneous();
      bus.W_SEND = 1'b1;
      for (int i = 0; i < 3; i++) begin bus.W_DATA = 16'($urandom); tick(); end
      bus.R_ACK = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.W_DATA = 16'($urandom); #1;
         total_cnt++;
         if ({bus.W_ACK, bus.R_COUNT, bus.R_DATA} !== {1'b1, 16'h0003, q[0]})
            $display("FAIL simul[%0d]: got ack=%b cnt=%h data=%h want 1/0003/%h",
                     i, bus.W_ACK, bus.R_COUNT, bus.R_DATA, q[0]);
         else pass_cnt++;
         tick();
      end
      bus.R_ACK = 1'b0;
      for (int i = 0; i < 5; i++) begin bus.W_DATA = 16'($urandom); tick(); end
      bus.R_ACK = 1'b1; #1;
      total_cnt++;
      if ({bus.W_ACK, bus.W_RDY, bus.R_COUNT} !== {1'b0, 1'b0, 16'h0008})
         $display("FAIL simul_full: got ack=%b rdy=%b cnt=%h want 0/0/0008", bus.W_ACK, bus.W_RDY, bus.R_COUNT);
      else pass_cnt++;
      tick();
      bus.W_SEND = 1'b0; bus.R_ACK = 1'b0; #1;
      total_cnt++;
      if ({bus.W_RDY, bus.R_COUNT} !== {1'b1, 16'h0007})
         $display("FAIL simul_after_full: got rdy=%b cnt=%h want 1/0007", bus.W_RDY, bus.R_COUNT);
      else pass_cnt++;
      bus.R_ACK = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         total_cnt++;
         if (bus.R_DATA !== q[0]) $display("FAIL simul_drain[%0d]: got %h want %h", i, bus.R_DATA, q[0]);
         else pass_cnt++;
         tick();
      end
      bus.R_ACK = 1'b0;
   endtask

   task automatic test_empty();
      bus.W_SEND = 1'b0; bus.R_ACK = 1'b1;
      tick(); tick();
      total_cnt++;
      if ({bus.R_SEND, bus.R_COUNT} !== {1'b0, 16'h0000})
         $display("FAIL empty_ack: got send=%b cnt=%h want 0/0000", bus.R_SEND, bus.R_COUNT);
      else pass_cnt++;
      bus.W_SEND = 1'b1; bus.W_DATA = 16'h1234; #1;
      total_cnt++;
      if (bus.W_ACK !== 1'b1) $display("FAIL empty_push_ack: got %b want 1", bus.W_ACK);
      else pass_cnt++;
      tick();
      bus.W_SEND = 1'b0; bus.R_ACK = 1'b0; #1;
      total_cnt++;
      if ({bus.R_SEND, bus.R_DATA, bus.R_COUNT} !== {1'b1, 16'h1234, 16'h0001})
         $display("FAIL empty_push: got send=%b data=%h cnt=%h want 1/1234/0001",
                  bus.R_SEND, bus.R_DATA, bus.R_COUNT);
      else pass_cnt++;
      bus.R_ACK = 1'b1; tick(); bus.R_ACK = 1'b0;
   endtask

   task automatic test_random();
      bit e_rdy, e_ack, e_send;
      for (int i = 0; i < 400; i++) begin
         if ((i / 100) % 2 == 0) begin
            bus.W_SEND = ($urandom_range(0, 3) != 0); bus.R_ACK = ($urandom_range(0, 3) == 0);
         end else begin
            bus.W_SEND = ($urandom_range(0, 3) == 0); bus.R_ACK = ($urandom_range(0, 3) != 0);
         end
         bus.W_DATA = 16'($urandom); #1;
         e_rdy = live_m && (q.size() < 8); e_ack = bus.W_SEND && e_rdy; e_send = (q.size() > 0);
         total_cnt++;
         if ({bus.W_ACK, bus.W_RDY, bus.R_SEND, bus.R_COUNT} !== {e_ack, e_rdy, e_send, 16'(q.size())})
            $display("FAIL rand_ctl[%0d]: got ack=%b rdy=%b send=%b cnt=%0d want %b %b %b %0d",
                     i, bus.W_ACK, bus.W_RDY, bus.R_SEND, bus.R_COUNT, e_ack, e_rdy, e_send, q.size());
         else pass_cnt++;
         if (e_send) begin
            total_cnt++;
            if (bus.R_DATA !== q[0]) $display("FAIL rand_data[%0d]: got %h want %h", i, bus.R_DATA, q[0]);
            else pass_cnt++;
         end
         tick();
      end
      idle_inputs();
   endtask

`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
   task automatic test_err();
      idle_inputs();
      @(posedge CLK); #2; RESET = 1'b0;
      q.delete(); live_m = 1'b0; err_m = 1'b0;
      @(posedge CLK); #1; RESET = 1'b1;
      tick();
      total_cnt++;
      if (ERR !== 1'b0) $display("FAIL err_clear: got %b want 0", ERR);
      else pass_cnt++;
      bus.W_SEND = 1'b1; bus.W_DATA = 16'h5A5A; bus.W_COUNT = 16'h0002;
      tick();
      idle_inputs(); #1;
      total_cnt++;
      if ({ERR, bus.R_COUNT, bus.R_DATA} !== {err_m, 16'h0001, 16'h5A5A} || err_m !== 1'b1)
         $display("FAIL err_count: got err=%b cnt=%h data=%h want 1/0001/5a5a", ERR, bus.R_COUNT, bus.R_DATA);
      else pass_cnt++;
   endtask
`endif

   task automatic test_reset_mid();
      bus.W_SEND = 1'b1; bus.W_COUNT = 16'h0001;
      while (q.size() < 4) begin bus.W_DATA = 16'($urandom); tick(); end
      bus.W_SEND = 1'b0;
      @(posedge CLK); #3;
      RESET = 1'b0; #1;
      q.delete(); live_m = 1'b0; err_m = 1'b0;
      total_cnt++;
      if ({bus.R_SEND, bus.R_COUNT, bus.W_RDY, bus.R_DATA} !== {1'b0, 16'h0000, 1'b0, 16'h0000})
         $display("FAIL midreset_outs: got send=%b cnt=%h rdy=%b data=%h want 0/0000/0/0000",
                  bus.R_SEND, bus.R_COUNT, bus.W_RDY, bus.R_DATA);
      else pass_cnt++;
`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
      total_cnt++;
      if (ERR !== 1'b0) $display("FAIL midreset_err: got %b want 0", ERR);
      else pass_cnt++;
`endif
      @(posedge CLK); #1; RESET = 1'b1;
      tick();
      total_cnt++;
      if ({bus.W_RDY, bus.R_SEND} !== {1'b1, 1'b0})
         $display("FAIL midreset_recover: got rdy=%b send=%b want 1/0", bus.W_RDY, bus.R_SEND);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_empty();
      test_random();
`ifdef ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN
      test_err();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/actor_token_fifo.md
Name: actor_token_fifo

Overview:
- Single-clock token channel between two dataflow actors.
- Write side is the consumer end of an actor output port: it takes Out*_SEND/DATA/COUNT and returns Out*_ACK/RDY.
- Read side is the producer end of an actor input port: it drives In*_SEND/DATA/COUNT and takes In*_ACK.
- Decouples actor firings so an upstream actor can fire while the downstream actor stalls, up to DEPTH tokens.

Parameters:
- DATA_WIDTH, 16, token width.
- DEPTH, 8, token capacity; power of two, minimum 2.
- ADDR_WIDTH, 3, log2(DEPTH).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- W_SEND  in  1  upstream actor presents one token this cycle.
- W_DATA  in  DATA_WIDTH  token from upstream.
- W_COUNT  in  16  token count of the write; protocol value 16'h1.
- W_ACK  out  1  token accepted this cycle.
- W_RDY  out  1  space available; upstream may fire.
- R_SEND  out  1  head token valid (FIFO not empty).
- R_DATA  out  DATA_WIDTH  head token, first-word fall-through.
- R_COUNT  out  16  occupancy, zero-extended to 16 bits.
- R_ACK  in  1  downstream actor consumes the head token this cycle.

Behaviour:
- Reset (RESET=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, occupancy=0, storage cleared to 0, live flop=0.
  - Outputs: W_RDY=0, W_ACK=0, R_SEND=0, R_COUNT=0, R_DATA=0.
- live flop:
  - Set on the first CLK edge after RESET returns high.
  - W_RDY=live & ~full, so W_RDY rises one cycle after reset release.
- full = (occupancy==DEPTH); empty = (occupancy==0). Occupancy is ADDR_WIDTH+1 bits.
- Push:
  - push = W_SEND & W_RDY.
  - W_ACK = push, combinational, same cycle.
  - On the edge: mem[wr_ptr]<=W_DATA, wr_ptr increments modulo DEPTH.
- Pop:
  - pop = R_ACK & R_SEND.
  - On the edge: rd_ptr increments modulo DEPTH.
  - The next entry appears on R_DATA in the following cycle.
- Read outputs:
  - R_SEND = ~empty.
  - R_DATA = mem[rd_ptr] combinationally.
  - R_COUNT = occupancy.
- Write latency: a token pushed at edge N is visible on R_SEND/R_DATA in the cycle after edge N. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Occupancy unchanged, both pointers advance.
  - Legal at any occupancy from 1 to DEPTH-1.
  - At full, push is refused because W_RDY=0. The pop proceeds and W_RDY rises the next cycle.
  - At empty, R_ACK is ignored because R_SEND=0. The push proceeds.
- Illegal accesses, silently ignored with no state change:
  - W_SEND while W_RDY=0: token dropped, W_ACK=0.
  - R_ACK while R_SEND=0: nothing popped.
- W_COUNT is not used for control. Every accepted push stores exactly one token.
- Pointer wrap: wr_ptr/rd_ptr at DEPTH-1 advance to 0. Full and empty are distinguished by occupancy only.
- Reset mid-operation: all tokens are discarded immediately. Outputs go to their reset values asynchronously, without waiting for a clock edge.

Optional Feature:
- Macro: ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output ERR (1 bit), reset 0, sticky until RESET.
  - ERR is set on the edge after any of: W_SEND & ~W_RDY & live; R_ACK & empty; W_SEND & W_COUNT!=16'h1.
  - ERR never alters FIFO data or pointer behaviour.
- Undefined: no ERR port and no checking logic. Illegal accesses are ignored as described in Behaviour.

Test Plan:
- Reset release:
  - Hold RESET=0 for 3 cycles, then release.
  - W_RDY=0 throughout reset, W_RDY=1 on the cycle after release.
  - R_SEND=0, R_COUNT=0, R_DATA=0.
- Fill and drain, DEPTH=8:
  - Push 16'h0011..16'h0088 on consecutive cycles with R_ACK=0.
  - W_ACK=1 each cycle, R_COUNT reaches 8, then W_RDY=0.
  - A ninth push of 16'hDEAD gives W_ACK=0.
  - Drain with R_ACK=1: R_DATA reads 0011..0088 in order, then R_SEND=0, R_COUNT=0.
- Wrap-around:
  - Push 5 tokens, pop 5, then push 6 tokens 16'hA000..A005 and pop them.
  - Order is preserved across the pointer wrap; R_COUNT peaks at 6.
- Simultaneous push and pop:
  - Setup: occupancy 3. Then, for 10 cycles, W_SEND=1 and R_ACK=1 together.
  - R_COUNT stays 3 and output order matches input order.
  - At full, the same stimulus gives W_ACK=0 with a pop; the next cycle W_RDY=1 and R_COUNT=7.
- Empty corner case:
  - R_ACK=1 while empty: R_COUNT stays 0 and no state change.
  - Push at empty with R_ACK=1 in the same cycle: token 16'h1234 appears on R_DATA next cycle with R_COUNT=1.
- Reset mid-operation with ACTOR_TOKEN_FIFO_PROTOCOL_CHECK_EN defined:
  - Push with W_COUNT=16'h2: ERR=1 next cycle and the token is stored.
  - With 4 tokens queued, assert RESET=0 mid-cycle: R_SEND, R_COUNT and ERR go to 0 immediately, without a clock edge.
